// File: rtl/hex_reg_viewer_pkg.sv
// hex_reg_viewer_pkg: shared glyph table, view states and page-count helper
package hex_reg_viewer_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    // Active-low gfedcba glyphs for hex digits 0..F
    localparam logic [6:0] GLYPHS [16] = '{
        SEG_ZERO, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00,    7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {IDLE, HOLD, LIVE} view_state_t;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        return GLYPHS[nib];
    endfunction

    function automatic int calc_pages(input int data_w, input int num_digits);
        return (data_w + 4 * num_digits - 1) / (4 * num_digits);
    endfunction

endpackage

// File: rtl/hex_reg_viewer_btn_debounce.sv
// hex_reg_viewer_btn_debounce: synchronise, debounce and edge-detect one active-low button
module hex_reg_viewer_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2, level, level_q;
    logic [CW-1:0] cnt;

    // two-flop synchroniser, idles at the released level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {sync2, sync1} <= 2'b11;
        else          {sync2, sync1} <= {sync1, btn_n};
    end

    // accept a new level only after a full run of samples that differ from it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // one-cycle pulse on the released-to-pressed transition only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b1;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level_q & ~level;
        end
    end

endmodule

// File: rtl/hex_reg_viewer.sv
// hex_reg_viewer: register peek/track controller driving a paged seven-segment bank
module hex_reg_viewer
    import hex_reg_viewer_pkg::*;
#(
    parameter int NUM_REGS        = 5,
    parameter int DATA_W          = 32,
    parameter int NUM_DIGITS      = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SEL_W           = 3,
    localparam int PAGES          = calc_pages(DATA_W, NUM_DIGITS),
    localparam int PAGE_W         = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REGS*DATA_W-1:0] reg_bus,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       peek_btn_n,
    input  logic                       page_btn_n,
    input  logic                       live_mode,
    input  logic                       blank_lz,
    output logic [NUM_DIGITS*7-1:0]    seg_n,
    output logic [PAGE_W-1:0]          page,
    output logic                       sel_err,
    output logic                       view_valid
);

    localparam int PAGE_BITS = NUM_DIGITS * 4;
    localparam int PAD_W     = PAGES * PAGE_BITS;
    localparam logic [NUM_DIGITS*7-1:0] SEG_RST = {{(NUM_DIGITS-1){SEG_BLANK}}, SEG_ZERO};

    logic                    peek_ev, page_ev;
    logic [DATA_W-1:0]       src, snapshot;
    logic [PAD_W-1:0]        padded;
    logic [PAGE_BITS-1:0]    shown;
    logic [NUM_DIGITS*7-1:0] seg_next;
    int                      msd;
    view_state_t             state;

    hex_reg_viewer_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_peek (
        .clk(clk), .reset_n(reset_n), .btn_n(peek_btn_n), .press(peek_ev)
    );

    hex_reg_viewer_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_page (
        .clk(clk), .reset_n(reset_n), .btn_n(page_btn_n), .press(page_ev)
    );

    // register select; unpopulated selects read as zero
    always_comb begin
        src = '0;
        for (int r = 0; r < NUM_REGS; r++)
            if (int'(sel) == r) src = reg_bus[r*DATA_W +: DATA_W];
    end

    // page counter wrapping at the last page
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     page <= '0;
        else if (page_ev) page <= (int'(page) == PAGES - 1) ? '0 : page + 1'b1;
    end

    // view FSM: first peek leaves IDLE, then live_mode picks tracking or frozen snapshot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            snapshot   <= '0;
            view_valid <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            sel_err <= int'(sel) >= NUM_REGS;
            if (state == IDLE) begin
                if (peek_ev) begin
                    snapshot   <= src;
                    state      <= live_mode ? LIVE : HOLD;
                    view_valid <= 1'b1;
                end
            end else begin
                if (peek_ev || live_mode) snapshot <= src;
                state <= live_mode ? LIVE : HOLD;
            end
        end
    end

    // pick the shown page, find its top nonzero digit and decode with optional blanking
    always_comb begin
        padded = PAD_W'(snapshot);
        shown  = '0;
        for (int p = 0; p < PAGES; p++)
            if (int'(page) == p) shown = padded[p*PAGE_BITS +: PAGE_BITS];
        msd = 0;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (shown[d*4 +: 4] != 4'h0) msd = d;
        for (int d = 0; d < NUM_DIGITS; d++)
            seg_next[d*7 +: 7] = (blank_lz && d > msd) ? SEG_BLANK : glyph(shown[d*4 +: 4]);
    end

    // registered segment drive
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) seg_n <= SEG_RST;
        else          seg_n <= seg_next;
    end

endmodule

// File: tb/tb_hex_reg_viewer.sv
// tb_hex_reg_viewer: randomized and directed check of 32-bit and 48-bit viewers against a behavioural model
module tb_hex_reg_viewer;

    localparam int D = 4;
    localparam logic [55:0] SEG_RST   = {{7{7'h7F}}, 7'h40};
    localparam logic [55:0] P0_LIT    = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    localparam logic [55:0] P1_LIT    = {{4{7'h40}}, 7'h08, 7'h03, 7'h46, 7'h21};

    logic        clk = 0, reset_n = 0, peek_btn_n = 1, page_btn_n = 1, live_mode = 0, blank_lz = 0;
    logic [2:0]  sel = 0;
    logic [31:0] r32 [5];
    logic [47:0] r48 [5];
    logic [159:0] bus32;
    logic [239:0] bus48;
    logic [55:0] seg32, seg48;
    logic        pg32, pg48, err32, err48, vv32, vv48;
    int          total = 0, bad = 0;

    bit          hpk [D+2], hpg [D+2];
    bit          dbk, dbg, flk, flg, evk, evg, mvalid, merr, mpg;
    logic [31:0] ms32;
    logic [47:0] ms48;
    logic [55:0] mseg32, mseg48;

    always_comb
        for (int i = 0; i < 5; i++) begin
            bus32[i*32 +: 32] = r32[i];
            bus48[i*48 +: 48] = r48[i];
        end

    hex_reg_viewer #(.NUM_REGS(5), .DATA_W(32), .NUM_DIGITS(8), .DEBOUNCE_CYCLES(D), .SEL_W(3)) dut32 (
        .clk(clk), .reset_n(reset_n), .reg_bus(bus32), .sel(sel), .peek_btn_n(peek_btn_n),
        .page_btn_n(page_btn_n), .live_mode(live_mode), .blank_lz(blank_lz),
        .seg_n(seg32), .page(pg32), .sel_err(err32), .view_valid(vv32)
    );

    hex_reg_viewer #(.NUM_REGS(5), .DATA_W(48), .NUM_DIGITS(8), .DEBOUNCE_CYCLES(D), .SEL_W(3)) dut48 (
        .clk(clk), .reset_n(reset_n), .reg_bus(bus48), .sel(sel), .peek_btn_n(peek_btn_n),
        .page_btn_n(page_btn_n), .live_mode(live_mode), .blank_lz(blank_lz),
        .seg_n(seg48), .page(pg48), .sel_err(err48), .view_valid(vv48)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [55:0] render(logic [63:0] v, int pg, bit blz);
        logic [55:0] o;
        logic [3:0]  nb;
        int          top = 0;
        for (int d = 0; d < 8; d++) begin
            nb = 4'(v >> ((pg * 8 + d) * 4));
            if (nb != 0) top = d;
        end
        for (int d = 0; d < 8; d++) begin
            nb = 4'(v >> ((pg * 8 + d) * 4));
            o[d*7 +: 7] = (blz && d > top) ? 7'h7F : glyph(nb);
        end
        return o;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a button level flips once the last D synchronised samples all disagree with it;
    // the press is seen by the viewer two edges after that flip, and seg shows the prior edge's view.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            for (int i = 0; i < D + 2; i++) begin hpk[i] = 1; hpg[i] = 1; end
            dbk = 1; dbg = 1; flk = 0; flg = 0; evk = 0; evg = 0;
            mvalid = 0; merr = 0; mpg = 0; ms32 = 0; ms48 = 0;
            mseg32 = SEG_RST; mseg48 = SEG_RST;
        end else begin
            bit ck, cg, fk, fg;
            ck = evk; cg = evg;
            evk = flk; evg = flg;
            for (int i = D + 1; i > 0; i--) begin hpk[i] = hpk[i-1]; hpg[i] = hpg[i-1]; end
            hpk[0] = peek_btn_n; hpg[0] = page_btn_n;
            fk = 1; fg = 1;
            for (int i = 2; i <= D + 1; i++) begin
                if (hpk[i] == dbk) fk = 0;
                if (hpg[i] == dbg) fg = 0;
            end
            flk = fk & dbk; flg = fg & dbg;
            if (fk) dbk = ~dbk;
            if (fg) dbg = ~dbg;
            mseg32 = render(64'(ms32), 0, blank_lz);
            mseg48 = render(64'(ms48), int'(mpg), blank_lz);
            if (ck || (mvalid && live_mode)) begin
                ms32 = 0; ms48 = 0;
                for (int i = 0; i < 5; i++)
                    if (int'(sel) == i) begin ms32 = r32[i]; ms48 = r48[i]; end
            end
            if (ck) mvalid = 1;
            if (cg) mpg = ~mpg;
            merr = sel >= 3'd5;
        end
    end

    // per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        chk("seg32", 64'(seg32), 64'(mseg32));
        chk("seg48", 64'(seg48), 64'(mseg48));
        chk("page32", 64'(pg32), 64'(0));
        chk("page48", 64'(pg48), 64'(mpg));
        chk("sel_err32", 64'(err32), 64'(merr));
        chk("sel_err48", 64'(err48), 64'(merr));
        chk("valid32", 64'(vv32), 64'(mvalid));
        chk("valid48", 64'(vv48), 64'(mvalid));
    end

    task automatic press(bit pk, bit pg, int hold);
        @(negedge clk);
        if (pk) peek_btn_n = 0;
        if (pg) page_btn_n = 0;
        repeat (hold) @(negedge clk);
        peek_btn_n = 1;
        page_btn_n = 1;
        repeat (D + 6) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin r32[i] = 0; r48[i] = 0; end
        repeat (3) @(negedge clk);
        chk("reset_seg32", 64'(seg32), 64'(SEG_RST));
        chk("reset_valid", 64'(vv32), 64'(0));
        reset_n = 1;
        r32[0] = 32'h0000_3FBA;
        r48[0] = 48'hABCD_1234_5678;
        repeat (2) @(negedge clk);

        peek_btn_n = 0;
        repeat (7) @(negedge clk);
        chk("valid_before_event", 64'(vv32), 64'(0));
        @(negedge clk);
        chk("valid_after_event", 64'(vv32), 64'(1));
        chk("seg_lag", 64'(seg32), 64'({8{7'h40}}));
        @(negedge clk);
        chk("seg32_3fba", 64'(seg32), 64'({{4{7'h40}}, 7'h30, 7'h0E, 7'h03, 7'h08}));
        chk("seg48_page0", 64'(seg48), 64'(P0_LIT));
        @(negedge clk);
        peek_btn_n = 1;
        repeat (10) @(negedge clk);

        blank_lz = 1;
        repeat (2) @(negedge clk);
        chk("blank_3fba", 64'(seg32), 64'({{4{7'h7F}}, 7'h30, 7'h0E, 7'h03, 7'h08}));
        r32[0] = 0;
        press(1, 0, 10);
        chk("blank_zero", 64'(seg32), 64'(SEG_RST));

        r32[0] = 32'h0000_0C0D;
        for (int i = 0; i < 10; i++) begin
            peek_btn_n = ~peek_btn_n;
            repeat (2) @(negedge clk);
        end
        press(1, 0, 10);
        chk("bounce_0c0d", 64'(seg32), 64'({{5{7'h7F}}, 7'h46, 7'h40, 7'h21}));

        sel = 3'd6;
        press(1, 0, 10);
        chk("sel_err_set", 64'(err32), 64'(1));
        chk("sel_err_seg", 64'(seg32), 64'(SEG_RST));
        sel = 3'd2;
        r32[2] = 32'h1234;
        @(negedge clk);
        chk("sel_err_clear", 64'(err32), 64'(0));
        chk("sel_err_hold", 64'(seg32), 64'(SEG_RST));

        blank_lz = 0;
        sel = 3'd1;
        r32[1] = 32'h100;
        live_mode = 1;
        repeat (20) begin @(negedge clk); r32[1] = r32[1] + 1; end
        live_mode = 0;
        repeat (10) begin @(negedge clk); r32[1] = r32[1] + 1; end

        sel = 3'd0;
        r48[0] = 48'hABCD_1234_5678;
        press(1, 0, 10);
        chk("p0_again", 64'(seg48), 64'(P0_LIT));
        press(0, 1, 10);
        chk("page_adv", 64'(pg48), 64'(1));
        chk("p1_abcd", 64'(seg48), 64'(P1_LIT));
        press(0, 1, 10);
        chk("page_wrap", 64'(pg48), 64'(0));
        chk("p0_wrap", 64'(seg48), 64'(P0_LIT));
        r48[0] = 48'h0042_0000_0000;
        press(1, 1, 10);
        chk("both_page", 64'(pg48), 64'(1));
        chk("both_seg", 64'(seg48), 64'({{6{7'h40}}, 7'h19, 7'h24}));

        @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("rst_page", 64'(pg48), 64'(0));
        chk("rst_seg48", 64'(seg48), 64'(SEG_RST));
        chk("rst_valid", 64'(vv48), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1;

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) peek_btn_n = ~peek_btn_n;
            if ($urandom_range(0, 13) == 0) page_btn_n = ~page_btn_n;
            if ($urandom_range(0, 59) == 0) begin peek_btn_n = 0; page_btn_n = 0; end
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = int'($urandom_range(0, 4));
                r32[k] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
                r48[k] = {16'($urandom), $urandom};
            end
            if ($urandom_range(0, 19) == 0) sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) live_mode = ~live_mode;
            if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
